// File: rtl/lsu_split_pkg.sv
// Shared LSU types: FSM states, funct3 encodings and access-size helpers.
// Imported by the LSU datapath and control.
package common;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ0,
    S_WAIT0,
    S_REQ1,
    S_WAIT1,
    S_RESP
  } lsu_state_t;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // byte mask of an access of size code sz (00 byte, 01 half, else word)
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    logic [3:0] m;
    case (sz)
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // number of bytes of an access of size code sz
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    logic [2:0] n;
    case (sz)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment: byte enables and store data for both beats,
// and merge/extension of load data from one or two words.
module lsu_align
  import common::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_sz,
  input  logic [2:0]  i_f3,
  input  logic        i_split,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata0,
  input  logic [31:0] i_rdata1,
  output logic [3:0]  o_be0,
  output logic [3:0]  o_be1,
  output logic [31:0] o_wdata0,
  output logic [31:0] o_wdata1,
  output logic [31:0] o_ldata
);

  logic [4:0]  w_sh;
  logic [7:0]  w_be;
  logic [63:0] w_wd;
  logic [63:0] w_rd;
  logic [31:0] w_raw;

  assign w_sh = {i_off, 3'b000};

  // bytes that spill past lane 3 land in the upper half: beat 1
  assign w_be     = {4'b0000, size_mask(i_sz)} << i_off;
  assign o_be0    = w_be[3:0];
  assign o_be1    = w_be[7:4];
  assign w_wd     = {32'h0, i_wdata} << w_sh;
  assign o_wdata0 = w_wd[31:0];
  assign o_wdata1 = w_wd[63:32];

  assign w_rd  = {(i_split ? i_rdata1 : 32'h0), i_rdata0} >> w_sh;
  assign w_raw = w_rd[31:0];

  // sign/zero extend the low bytes according to the load type
  always_comb begin
    o_ldata = w_raw;
    case (i_f3)
      F3_LB:   o_ldata = {{24{w_raw[7]}}, w_raw[7:0]};
      F3_LH:   o_ldata = {{16{w_raw[15]}}, w_raw[15:0]};
      F3_LBU:  o_ldata = {24'h0, w_raw[7:0]};
      F3_LHU:  o_ldata = {16'h0, w_raw[15:0]};
      default: o_ldata = w_raw;
    endcase
  end

endmodule

// File: rtl/lsu_split.sv
// MEM-stage load/store unit: one request at a time, optional
// splitting of word-crossing accesses into two aligned beats.
module lsu_split
  import common::*;
#(
  parameter bit ALLOW_SPLIT = 1'b1,
  parameter int RD_W        = 5
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_is_store,
  input  logic [2:0]      i_req_funct3,
  input  logic [31:0]     i_req_base,
  input  logic [31:0]     i_req_offset,
  input  logic [31:0]     i_req_wdata,
  input  logic [RD_W-1:0] i_req_rd,
  output logic            o_resp_valid,
  output logic [31:0]     o_resp_rdata,
  output logic [RD_W-1:0] o_resp_rd,
  output logic            o_resp_misaligned,
  output logic            o_mem_req,
  input  logic            i_mem_gnt,
  output logic [31:0]     o_mem_addr,
  output logic            o_mem_we,
  output logic [3:0]      o_mem_be,
  output logic [31:0]     o_mem_wdata,
  input  logic            i_mem_rvalid,
  input  logic [31:0]     i_mem_rdata
);

  lsu_state_t      r_state;
  logic [1:0]      r_off;
  logic [1:0]      r_sz;
  logic [2:0]      r_f3;
  logic            r_store;
  logic            r_split;
  logic [31:0]     r_wdata;
  logic [RD_W-1:0] r_rd;
  logic [31:0]     r_rdata0;
  logic            r_mem_req;
  logic [31:0]     r_mem_addr;
  logic            r_mem_we;
  logic [3:0]      r_mem_be;
  logic [31:0]     r_mem_wdata;
  logic            r_resp_valid;
  logic [31:0]     r_resp_rdata;
  logic            r_resp_mis;

  logic        w_idle;
  logic [31:0] w_ea;
  logic [1:0]  w_sz;
  logic [2:0]  w_nb;
  logic        w_cross;
  logic        w_unal;
  logic        w_mis;
  logic        w_split;
  logic [1:0]  w_a_off;
  logic [1:0]  w_a_sz;
  logic [2:0]  w_a_f3;
  logic        w_a_split;
  logic [31:0] w_a_wdata;
  logic [31:0] w_a_rdata0;
  logic [3:0]  w_be0;
  logic [3:0]  w_be1;
  logic [31:0] w_wd0;
  logic [31:0] w_wd1;
  logic [31:0] w_ldata;

  assign w_idle  = (r_state == S_IDLE);
  assign w_ea    = i_req_base + i_req_offset;
  assign w_sz    = (i_req_funct3[1:0] == 2'b11) ? 2'b10
                 : i_req_funct3[1:0];
  assign w_nb    = size_bytes(w_sz);
  assign w_cross = ({1'b0, w_ea[1:0]} + w_nb) > 3'd4;
  assign w_unal  = (w_sz == 2'b01) ? w_ea[0]
                 : (w_sz == 2'b10) ? |w_ea[1:0]
                 : 1'b0;
  assign w_mis   = ALLOW_SPLIT ? 1'b0 : w_unal;
  assign w_split = ALLOW_SPLIT & w_cross;

  // while idle the aligner sees the live request so beat 0 can be
  // launched on the accepting edge; afterwards the captured copy
  assign w_a_off    = w_idle ? w_ea[1:0] : r_off;
  assign w_a_sz     = w_idle ? w_sz : r_sz;
  assign w_a_f3     = w_idle ? i_req_funct3 : r_f3;
  assign w_a_split  = w_idle ? w_split : r_split;
  assign w_a_wdata  = w_idle ? i_req_wdata : r_wdata;
  assign w_a_rdata0 = (r_state == S_WAIT0) ? i_mem_rdata : r_rdata0;

  lsu_align u_align (
    .i_off    (w_a_off),
    .i_sz     (w_a_sz),
    .i_f3     (w_a_f3),
    .i_split  (w_a_split),
    .i_wdata  (w_a_wdata),
    .i_rdata0 (w_a_rdata0),
    .i_rdata1 (i_mem_rdata),
    .o_be0    (w_be0),
    .o_be1    (w_be1),
    .o_wdata0 (w_wd0),
    .o_wdata1 (w_wd1),
    .o_ldata  (w_ldata)
  );

  // request sequencer: beats, data capture and the response pulse
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_off        <= 2'b00;
      r_sz         <= 2'b00;
      r_f3         <= 3'b000;
      r_store      <= 1'b0;
      r_split      <= 1'b0;
      r_wdata      <= 32'h0;
      r_rd         <= '0;
      r_rdata0     <= 32'h0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= 4'b0000;
      r_mem_wdata  <= 32'h0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_mis   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_off        <= w_ea[1:0];
            r_sz         <= w_sz;
            r_f3         <= i_req_funct3;
            r_store      <= i_req_is_store;
            r_split      <= w_split;
            r_wdata      <= i_req_wdata;
            r_rd         <= i_req_rd;
            r_resp_rdata <= 32'h0;
            r_resp_mis   <= 1'b0;
            if (w_mis) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_mis   <= 1'b1;
            end else begin
              r_state     <= S_REQ0;
              r_mem_req   <= 1'b1;
              r_mem_addr  <= {w_ea[31:2], 2'b00};
              r_mem_be    <= w_be0;
              r_mem_we    <= i_req_is_store;
              r_mem_wdata <= i_req_is_store ? w_wd0 : 32'h0;
            end
          end
        end
        S_REQ0: begin
          if (i_mem_gnt) begin
            if (!r_store) begin
              r_mem_req <= 1'b0;
              r_state   <= S_WAIT0;
            end else if (r_split) begin
              r_state     <= S_REQ1;
              r_mem_addr  <= r_mem_addr + 32'd4;
              r_mem_be    <= w_be1;
              r_mem_wdata <= w_wd1;
            end else begin
              r_mem_req    <= 1'b0;
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
            end
          end
        end
        S_WAIT0: begin
          if (i_mem_rvalid) begin
            r_rdata0 <= i_mem_rdata;
            if (r_split) begin
              r_state    <= S_REQ1;
              r_mem_req  <= 1'b1;
              r_mem_addr <= r_mem_addr + 32'd4;
              r_mem_be   <= w_be1;
            end else begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= w_ldata;
            end
          end
        end
        S_REQ1: begin
          if (i_mem_gnt) begin
            r_mem_req <= 1'b0;
            if (r_store) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
            end else begin
              r_state <= S_WAIT1;
            end
          end
        end
        S_WAIT1: begin
          if (i_mem_rvalid) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_ldata;
          end
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_mem_be     <= 4'b0000;
          r_mem_we     <= 1'b0;
          r_resp_rdata <= 32'h0;
          r_resp_mis   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready       = w_idle;
  assign o_resp_valid      = r_resp_valid;
  assign o_resp_rdata      = r_resp_rdata;
  assign o_resp_rd         = r_rd;
  assign o_resp_misaligned = r_resp_mis;
  assign o_mem_req         = r_mem_req;
  assign o_mem_addr        = r_mem_addr;
  assign o_mem_we          = r_mem_we;
  assign o_mem_be          = r_mem_be;
  assign o_mem_wdata       = r_mem_wdata;

endmodule

// File: tb/tb_lsu_split.sv
// Randomized bench for lsu_split against a byte-level memory model.
// A second instance covers the misaligned-fault configuration.
module tb_lsu_split;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base, req_offset, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_mis;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        b_valid, b_ready, b_store;
  logic [2:0]  b_f3;
  logic [31:0] b_base, b_off, b_wdata;
  logic [4:0]  b_rd;
  logic        b_rvalid_o, b_mis;
  logic [31:0] b_rdata_o;
  logic [4:0]  b_rd_o;
  logic        b_mem_req, b_gnt, b_we, b_rvalid;
  logic [31:0] b_addr, b_wd_o, b_rdata;
  logic [3:0]  b_be;

  lsu_split #(.ALLOW_SPLIT(1'b1), .RD_W(5)) u_dut (
    .i_clk(clk), .i_reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_is_store(req_is_store), .i_req_funct3(req_funct3),
    .i_req_base(req_base), .i_req_offset(req_offset),
    .i_req_wdata(req_wdata), .i_req_rd(req_rd),
    .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata),
    .o_resp_rd(resp_rd), .o_resp_misaligned(resp_mis),
    .o_mem_req(mem_req), .i_mem_gnt(mem_gnt),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_be(mem_be),
    .o_mem_wdata(mem_wdata), .i_mem_rvalid(mem_rvalid),
    .i_mem_rdata(mem_rdata)
  );

  lsu_split #(.ALLOW_SPLIT(1'b0), .RD_W(5)) u_dut_ns (
    .i_clk(clk), .i_reset(reset),
    .i_req_valid(b_valid), .o_req_ready(b_ready),
    .i_req_is_store(b_store), .i_req_funct3(b_f3),
    .i_req_base(b_base), .i_req_offset(b_off),
    .i_req_wdata(b_wdata), .i_req_rd(b_rd),
    .o_resp_valid(b_rvalid_o), .o_resp_rdata(b_rdata_o),
    .o_resp_rd(b_rd_o), .o_resp_misaligned(b_mis),
    .o_mem_req(b_mem_req), .i_mem_gnt(b_gnt),
    .o_mem_addr(b_addr), .o_mem_we(b_we), .o_mem_be(b_be),
    .o_mem_wdata(b_wd_o), .i_mem_rvalid(b_rvalid),
    .i_mem_rdata(b_rdata)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // byte-addressed memory; untouched bytes read a fixed pattern
  logic [7:0] mem [bit [31:0]];

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {rd_byte(a + 3), rd_byte(a + 2), rd_byte(a + 1), rd_byte(a)};
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
  } beat_t;

  beat_t       beats[$];
  int          gnt_stall = -1;
  int          rv_dly    = -1;
  bit          pend      = 1'b0;
  int          pend_cnt  = 0;
  logic [31:0] pend_data = 32'h0;

  // memory responder: grant after a stall, return data after a delay
  initial begin : responder
    bit    new_beat;
    int    stall_cnt;
    beat_t snap;
    new_beat   = 1'b1;
    stall_cnt  = 0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (pend) begin
        if (pend_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = pend_data;
          pend       = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      mem_gnt = 1'b0;
      if (mem_req) begin
        if (new_beat) begin
          snap = '{mem_addr, mem_be, mem_we, mem_wdata};
          stall_cnt = (gnt_stall < 0) ? int'($urandom_range(2, 0))
                                      : gnt_stall;
          new_beat = 1'b0;
        end else begin
          chk("addr_stable", mem_addr, snap.addr);
          chk("be_stable", 32'(mem_be), 32'(snap.be));
          chk("wdata_stable", mem_wdata, snap.wd);
        end
        if (stall_cnt == 0) begin
          mem_gnt  = 1'b1;
          new_beat = 1'b1;
          beats.push_back(snap);
          if (snap.we) begin
            for (int i = 0; i < 4; i++)
              if (snap.be[i]) mem[snap.addr + i] = snap.wd[8*i +: 8];
          end else begin
            pend      = 1'b1;
            pend_cnt  = (rv_dly < 0) ? int'($urandom_range(2, 0)) : rv_dly;
            pend_data = rd_word(snap.addr);
          end
        end else begin
          stall_cnt--;
        end
      end else begin
        new_beat = 1'b1;
      end
    end
  end

  // one request on the split-capable unit, checked against byte semantics
  task automatic run(input bit st, input logic [2:0] f3,
                     input logic [31:0] base, input logic [31:0] off,
                     input logic [31:0] wd, input logic [4:0] rd,
                     input int exp_lat, output logic [31:0] got);
    logic [31:0] ea, a, raw, expv;
    logic [31:0] ew [2];
    logic [3:0]  eb [2];
    logic [31:0] ed [2];
    logic [7:0]  nb_lo, nb_hi;
    int n, nb, k, t0, lat, lane;
    got = 32'h0;
    ea  = base + off;
    n   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    nb  = 0;
    raw = 32'h0;
    for (int i = 0; i < 2; i++) begin
      ew[i] = 32'h0; eb[i] = 4'h0; ed[i] = 32'h0;
    end
    for (int i = 0; i < n; i++) begin
      a    = ea + i;
      lane = int'(a[1:0]);
      if (nb == 0 || ew[nb-1] != {a[31:2], 2'b00}) begin
        ew[nb] = {a[31:2], 2'b00};
        nb++;
      end
      eb[nb-1][lane]         = 1'b1;
      ed[nb-1][8*lane +: 8]  = wd[8*i +: 8];
      raw[8*i +: 8]          = rd_byte(a);
    end
    case (f3)
      3'b000:  expv = {{24{raw[7]}}, raw[7:0]};
      3'b001:  expv = {{16{raw[15]}}, raw[15:0]};
      3'b100:  expv = {24'h0, raw[7:0]};
      3'b101:  expv = {16'h0, raw[15:0]};
      default: expv = raw;
    endcase
    if (st) expv = 32'h0;
    nb_lo = rd_byte(ea - 1);
    nb_hi = rd_byte(ea + n);
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_base     = base;
    req_offset   = off;
    req_wdata    = wd;
    req_rd       = rd;
    t0 = cyc + 1;
    beats.delete();
    @(negedge clk);
    req_valid  = 1'b0;
    req_base   = $urandom;
    req_offset = $urandom;
    req_wdata  = $urandom;
    k = 0;
    while (!resp_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!resp_valid) begin
      chk("resp_timeout", 32'd0, 32'd1);
      return;
    end
    lat = cyc - t0 + 1;
    if (exp_lat >= 0) chk("latency", 32'(lat), 32'(exp_lat));
    got = resp_rdata;
    chk("rdata", resp_rdata, expv);
    chk("resp_rd", 32'(resp_rd), 32'(rd));
    chk("no_misaligned", 32'(resp_mis), 32'd0);
    chk("beat_count", 32'(beats.size()), 32'(nb));
    for (int i = 0; i < nb && i < beats.size(); i++) begin
      chk("beat_addr", beats[i].addr, ew[i]);
      chk("beat_be", 32'(beats[i].be), 32'(eb[i]));
      chk("beat_we", 32'(beats[i].we), 32'(st));
      if (st) chk("beat_wdata", beats[i].wd & be_mask(eb[i]), ed[i]);
    end
    if (st) begin
      for (int i = 0; i < n; i++)
        chk("mem_byte", 32'(rd_byte(ea + i)), 32'(wd[8*i +: 8]));
      chk("mem_below", 32'(rd_byte(ea - 1)), 32'(nb_lo));
      chk("mem_above", 32'(rd_byte(ea + n)), 32'(nb_hi));
    end
    @(negedge clk);
    chk("resp_pulse", 32'(resp_valid), 32'd0);
    chk("ready_back", 32'(req_ready), 32'd1);
  endtask

  int b_req_cycles = 0;
  initial forever begin
    @(negedge clk);
    if (b_mem_req) b_req_cycles++;
  end

  // one request on the non-splitting unit (faults and stores only)
  task automatic run_b(input bit st, input logic [2:0] f3,
                       input logic [31:0] ea, input bit exp_mis,
                       input int exp_lat);
    int k, t0;
    logic [4:0] rd;
    rd = 5'($urandom);
    k  = 0;
    while (!b_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    b_valid = 1'b1;
    b_store = st;
    b_f3    = f3;
    b_base  = $urandom;
    b_off   = ea - b_base;
    b_wdata = $urandom;
    b_rd    = rd;
    t0 = cyc + 1;
    @(negedge clk);
    b_valid = 1'b0;
    k = 0;
    while (!b_rvalid_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!b_rvalid_o) begin
      chk("b_resp_timeout", 32'd0, 32'd1);
      return;
    end
    chk("b_latency", 32'(cyc - t0 + 1), 32'(exp_lat));
    chk("b_misaligned", 32'(b_mis), 32'(exp_mis));
    chk("b_rdata", b_rdata_o, 32'h0);
    chk("b_resp_rd", 32'(b_rd_o), 32'(rd));
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, ea;
    bit          st;
    logic [2:0]  f3;
    int          b_stores, sel;
    reset = 1'b1;
    req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b0;
    req_base = 32'h0; req_offset = 32'h0; req_wdata = 32'h0;
    req_rd = 5'h0;
    b_valid = 1'b0; b_store = 1'b0; b_f3 = 3'b0; b_base = 32'h0;
    b_off = 32'h0; b_wdata = 32'h0; b_rd = 5'h0;
    b_gnt = 1'b1; b_rvalid = 1'b0; b_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_mis", 32'(resp_mis), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    gnt_stall = 0;
    rv_dly    = 0;
    mem[32'h100] = 8'hEF; mem[32'h101] = 8'hBE;
    mem[32'h102] = 8'hAD; mem[32'h103] = 8'hDE;
    run(1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 5'd7, 3, got);
    chk("lw_data", got, 32'hDEADBEEF);
    chk("lw_be", 32'(beats[0].be), 32'hF);

    mem[32'h103] = 8'h80;
    run(1'b0, 3'b000, 32'h100, 32'h3, 32'h0, 5'd3, 3, got);
    chk("lb_data", got, 32'hFFFFFF80);
    chk("lb_be", 32'(beats[0].be), 32'h8);
    run(1'b0, 3'b100, 32'h103, 32'h0, 32'h0, 5'd4, 3, got);
    chk("lbu_data", got, 32'h00000080);

    run(1'b1, 3'b001, 32'h1F0, 32'hF, 32'h1234, 5'd9, 3, got);
    if (beats.size() == 2) begin
      chk("sh_b0_addr", beats[0].addr, 32'h1FC);
      chk("sh_b0_be", 32'(beats[0].be), 32'h8);
      chk("sh_b0_wd", beats[0].wd, 32'h34000000);
      chk("sh_b1_addr", beats[1].addr, 32'h200);
      chk("sh_b1_be", 32'(beats[1].be), 32'h1);
      chk("sh_b1_wd", beats[1].wd, 32'h00000012);
    end else begin
      chk("sh_beats", 32'(beats.size()), 32'd2);
    end
    run(1'b1, 3'b010, 32'h300, 32'h4, 32'hCAFEF00D, 5'd1, 2, got);

    mem[32'h102] = 8'hAA; mem[32'h103] = 8'hBB;
    mem[32'h104] = 8'hCC; mem[32'h105] = 8'hDD;
    run(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 5'd12, 5, got);
    chk("lw_split_data", got, 32'hDDCCBBAA);

    gnt_stall = 3;
    run(1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 5'd2, 6, got);
    run(1'b1, 3'b010, 32'h2FE, 32'h0, 32'h89ABCDEF, 5'd5, 9, got);

    gnt_stall = 0;
    rv_dly    = 4;
    req_valid    = 1'b1;
    req_is_store = 1'b0;
    req_funct3   = 3'b010;
    req_base     = 32'h100;
    req_offset   = 32'h0;
    req_rd       = 5'd21;
    beats.delete();
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_wait", 32'(beats.size()), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_req", 32'(mem_req), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_resp", 32'(resp_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stray_resp", 32'(resp_valid), 32'd0);
      chk("stray_idle", 32'(req_ready & ~mem_req), 32'd1);
    end

    gnt_stall = -1;
    rv_dly    = -1;
    for (int t = 0; t < 200; t++) begin
      st = 1'(($urandom >> 4) & 1);
      sel = int'($urandom_range(4, 0));
      if (st) f3 = 3'(sel % 4);
      else    f3 = (sel < 3) ? 3'(sel) : 3'(sel + 1);
      if ($urandom_range(7, 0) == 0) ea = 32'hFFFFFFF8 + $urandom_range(7, 0);
      else                           ea = 32'h1000 + $urandom_range(63, 0);
      run(st, f3, ea - 32'd5, 32'd5, $urandom, 5'($urandom), -1, got);
    end

    b_stores = 0;
    run_b(1'b0, 3'b010, 32'h102, 1'b1, 1);
    for (int t = 0; t < 12; t++) begin
      sel = int'($urandom_range(3, 0));
      case (sel)
        0: run_b(1'b0, 3'b001, {$urandom(31)} | 32'h1, 1'b1, 1);
        1: run_b(1'b1, 3'b010,
                 {30'($urandom), 2'($urandom_range(3, 1))}, 1'b1, 1);
        2: run_b(1'b0, 3'b101, {$urandom(31)} | 32'h1, 1'b1, 1);
        default: begin
          run_b(1'b1, 3'b000, $urandom, 1'b0, 2);
          b_stores++;
        end
      endcase
    end
    run_b(1'b1, 3'b010, 32'h200, 1'b0, 2);
    b_stores++;
    chk("b_mem_req_cycles", 32'(b_req_cycles), 32'(b_stores));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_split.md
# lsu_split

Parametrised, sequential load/store unit for the 32-bit RV32 core: computes the effective address, runs a req/gnt/rvalid handshake with data memory, generates byte enables, and extracts/sign-extends load data. When enabled it services accesses crossing a 32-bit word boundary as two aligned beats; otherwise it flags them as misaligned. Sits in the MEM stage between the execute result registers and the data memory port, stalling the pipeline through `req_ready`.

## Interface
- `ALLOW_SPLIT`, 1: 1 = split word-crossing accesses into two beats; 0 = report any access not naturally aligned to its size as misaligned.
- `RD_W`, 5: width of destination-register tag.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: MEM-stage request present.
- `req_ready` out 1: unit idle; request accepted when `req_valid & req_ready`.
- `req_is_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: load/store funct3; stores use [1:0], `2'b11` treated as word.
- `req_base` in 32: rs1 value.
- `req_offset` in 32: sign-extended immediate.
- `req_wdata` in 32: rs2 value (store data, LSB-justified).
- `req_rd` in RD_W: destination tag, returned with response.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and faults.
- `resp_rd` out RD_W: tag of completed request.
- `resp_misaligned` out 1: valid with `resp_valid`; access not performed.
- `mem_req` out 1, `mem_gnt` in 1: address-phase handshake; beat transfers when both high.
- `mem_addr` out 32: word-aligned address (bits [1:0] = 0).
- `mem_we` out 1, `mem_be` out 4, `mem_wdata` out 32: write enable, byte enables, lane-positioned data.
- `mem_rvalid` in 1, `mem_rdata` in 32: load data phase, earliest the cycle after gnt.

## Operation
- EA = `req_base + req_offset` (mod 2^32), captured with all request fields on acceptance. o = EA[1:0]; n = 1/2/4 bytes from funct3[1:0].
- Crossing: o + n > 4. Misaligned (ALLOW_SPLIT=0): EA mod n != 0. Misaligned requests skip memory: RESP with `resp_misaligned`=1.
- Beat0: addr = EA & ~3, be = ((1<<n)-1) << o (low 4 bits), wdata = wdata << 8o.
- Beat1 (crossing only): addr = beat0 addr + 4 (wraps at 2^32), be = ((1<<n)-1) >> (4-o), wdata = wdata >> 8(4-o).
- Load merge: raw = (rdata0 >> 8o) | (rdata1 << 8(4-o)) (rdata1 term only when split); take low n bytes; funct3 000/001 sign-extend, 100/101 zero-extend, 010 pass.
- FSM: IDLE -> REQ0 on accept (-> RESP if misaligned). REQ0 -> (load) WAIT0 / (store) REQ1 or RESP on gnt. WAIT0 -> REQ1 if split else RESP on rvalid. REQ1 -> WAIT1 (load) / RESP (store) on gnt. WAIT1 -> RESP on rvalid. RESP -> IDLE unconditionally.
- `mem_rvalid` outside WAIT0/WAIT1 ignored.

## Timing
- All outputs registered or decoded from state; reset values: state IDLE, `req_ready`=1, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`/`mem_wdata`=0, `resp_valid`=0, `resp_rdata`=0, `resp_misaligned`=0.
- `mem_req` high exactly in REQ0/REQ1; address-phase signals stable while `mem_req & !mem_gnt`.
- Best case (gnt immediate, rvalid next cycle), accept at edge t: aligned load resp_valid cycle t+3; aligned store t+2; split load t+5; split store t+3; misaligned fault t+1.
- `req_ready`=1 only in IDLE; no back-to-back overlap.
- Reset mid-operation: next cycle IDLE, `mem_req` dropped, no response; later stray rvalid ignored.

## Structure
- Package `common`: `lsu_state_t` enum, F3_LB/LH/LW/LBU/LHU constants alongside existing F3_SB/SH/SW, size-to-mask function.
- Sub-module `lsu_align`: combinational beat be/wdata generation and load merge/extend; FSM and registers in `lsu_split`.

## Test plan
- LW EA 0x100, rdata 0xDEADBEEF -> one beat addr 0x100 be 4'b1111, resp_rdata 0xDEADBEEF, resp_rd echoed.
- LB EA 0x103, rdata 0x80xxxxxx -> be 4'b1000, resp_rdata 0xFFFFFF80; LBU -> 0x00000080.
- SH wdata 0x1234 EA 0x1FF, ALLOW_SPLIT=1 -> beat0 addr 0x1FC be 4'b1000 wdata 0x34000000; beat1 addr 0x200 be 4'b0001 wdata 0x00000012.
- LW EA 0x102, rdata0 0xBBAAxxxx, rdata1 0xxxxxDDCC -> resp_rdata 0xDDCCBBAA; with ALLOW_SPLIT=0 -> no mem_req, resp_misaligned=1 at t+1.
- gnt held low 3 cycles -> mem_req/addr/be/wdata stable, latency grows by 3.
- reset asserted in WAIT0 -> IDLE next cycle, no resp_valid, following rvalid ignored.
